riscv_multiplier_seq: RTL



---
 rtl/riscv_multiplier_seq.sv | 133 +++++++++++++
 1 files changed

// File: rtl/riscv_multiplier_seq.sv
// Iterative RV32M multiplier: BITS_PER_CYCLE multiplier bits per clock, with a
// one-entry product cache so a MULH/MUL pair on the same operands costs one pass.
module riscv_multiplier_seq #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            valid_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic            stall_o
);
  localparam int ITER  = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(ITER) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_e;
  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            a_s;
    logic            b_s;
  } tag_t;

  state_e            state, state_nxt;
  tag_t              req, tag;
  logic              tag_vld, hit, accept, neg, neg_q;
  logic [1:0]        op_q;
  logic [XLEN-1:0]   mag_a, mag_b, mag_a_q, mag_b_q, res_q, half;
  logic [2*XLEN-1:0] acc, prod, pp, pp_sh;
  logic [CNT_W-1:0]  cnt;

  // Request decode: signedness, magnitudes and cache lookup.
  always_comb begin
    req.a   = a_i;
    req.b   = b_i;
    req.a_s = (op_i == 2'b01) || (op_i == 2'b10);
    req.b_s = (op_i == 2'b01);
    mag_a   = (req.a_s && a_i[XLEN-1]) ? -a_i : a_i;
    mag_b   = (req.b_s && b_i[XLEN-1]) ? -b_i : b_i;
    neg     = (req.a_s & a_i[XLEN-1]) ^ (req.b_s & b_i[XLEN-1]);
    // The low half is signedness-independent, so MUL matches on operands only.
    hit     = tag_vld && (a_i == tag.a) && (b_i == tag.b) &&
              ((op_i == 2'b00) || ((req.a_s == tag.a_s) && (req.b_s == tag.b_s)));
    accept  = valid_i && !flush_i && (state == IDLE);
  end

  always_comb begin
    pp    = {{XLEN{1'b0}}, mag_a_q} *
            {{(2*XLEN-BITS_PER_CYCLE){1'b0}}, mag_b_q[BITS_PER_CYCLE-1:0]};
    pp_sh = pp << (int'(cnt) * BITS_PER_CYCLE);
    half  = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = hit ? DONE : CALC;
      CALC: begin
        if (flush_i)          state_nxt = IDLE;
        else if (cnt == LAST) state_nxt = SIGN;
      end
      SIGN: state_nxt = flush_i ? IDLE : DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ready_o  = (state == IDLE);
  assign valid_o  = (state == DONE) && !flush_i;
  assign stall_o  = (valid_i && (state == IDLE) && !flush_i) || (state == CALC) || (state == SIGN);
  assign result_o = valid_o ? half : res_q;

  // A miss overwrites the tag at acceptance and only re-validates it once the
  // product lands, so any abort leaves the entry invalid.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      tag     <= '0;
      tag_vld <= 1'b0;
      op_q    <= 2'b00;
      neg_q   <= 1'b0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      acc     <= '0;
      prod    <= '0;
      cnt     <= '0;
      res_q   <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q <= op_i;
          if (!hit) begin
            tag     <= req;
            tag_vld <= 1'b0;
            neg_q   <= neg;
            mag_a_q <= mag_a;
            mag_b_q <= mag_b;
            acc     <= '0;
            cnt     <= '0;
          end
        end
        CALC: begin
          if (flush_i) tag_vld <= 1'b0;
          else begin
            acc     <= acc + pp_sh;
            mag_b_q <= mag_b_q >> BITS_PER_CYCLE;
            cnt     <= cnt + CNT_W'(1);
          end
        end
        SIGN: begin
          if (flush_i) tag_vld <= 1'b0;
          else begin
            prod    <= neg_q ? -acc : acc;
            tag_vld <= 1'b1;
          end
        end
        DONE: if (!flush_i) res_q <= half;
        default: ;
      endcase
    end
  end
endmodule
